// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the multi-port register file: read ports, writeback ports,
// issue strobe and scoreboard status. The master drives requests; the slave is the register file.
interface regfile_mp_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREG-1:0]     busy_vec;
  logic [AW:0]         busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec, busy_cnt
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard; register 0 is hardwired zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and issue/clear status to the read ports.
module regfile_mp_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic            clk,
  input  logic            rst,
  regfile_mp_sb_if.slave  bus
);
  localparam logic [AW:0] CNT_ONE = 1;

  logic [XLEN-1:0] regs   [1:NREG-1];
  logic [XLEN-1:0] wr_val [1:NREG-1];
  logic [NREG-1:0] busy_q, busy_n, wr_hit, iss_hit;
  logic [AW:0]     cnt_q, cnt_n;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'({1'b0, a}) < NREG);
  endfunction

  // Ascending port order lets the highest-index writer win a conflict.
  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int r = 1; r < NREG; r++) wr_val[r] = regs[r];
    for (int p = 0; p < NWR; p++) begin
      if (bus.wr_en[p] && addr_ok(bus.wr_addr[p*AW +: AW])) begin
        for (int r = 1; r < NREG; r++) begin
          if (int'({1'b0, bus.wr_addr[p*AW +: AW]}) == r) begin
            wr_hit[r] = 1'b1;
            wr_val[r] = bus.wr_data[p*XLEN +: XLEN];
          end
        end
      end
    end
    if (bus.iss_en && addr_ok(bus.iss_addr)) begin
      for (int r = 1; r < NREG; r++) begin
        if (int'({1'b0, bus.iss_addr}) == r) iss_hit[r] = 1'b1;
      end
    end
    // A same-edge issue overrides the writeback clear: the new producer owns the register.
    busy_n    = iss_hit | (busy_q & ~wr_hit);
    busy_n[0] = 1'b0;
    cnt_n     = cnt_q;
    for (int r = 1; r < NREG; r++) begin
      if (busy_n[r] && !busy_q[r])      cnt_n = cnt_n + CNT_ONE;
      else if (busy_q[r] && !busy_n[r]) cnt_n = cnt_n - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) regs[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) regs[r] <= wr_val[r];
      busy_q <= busy_n;
      cnt_q  <= cnt_n;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 1; r < NREG; r++) begin
        if (int'({1'b0, bus.rd_addr[k*AW +: AW]}) == r) begin
          bus.rd_data[k*XLEN +: XLEN] = regs[r];
          bus.rd_busy[k]              = busy_q[r];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (!rst) begin
        for (int p = 0; p < NWR; p++) begin
          if (bus.wr_en[p] && addr_ok(bus.wr_addr[p*AW +: AW]) &&
              bus.wr_addr[p*AW +: AW] == bus.rd_addr[k*AW +: AW]) begin
            bus.rd_data[k*XLEN +: XLEN] = bus.wr_data[p*XLEN +: XLEN];
            bus.rd_busy[k]              = 1'b0;
          end
        end
        if (bus.iss_en && addr_ok(bus.iss_addr) && bus.iss_addr == bus.rd_addr[k*AW +: AW])
          bus.rd_busy[k] = 1'b1;
      end
`endif
    end
  end

  assign bus.busy_vec = busy_q;
  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an array-based reference model.
module tb_regfile_mp_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  logic [XLEN-1:0] mreg  [NREG];
  bit              mbusy [NREG];

  regfile_mp_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid(input int a);
    return (a != 0) && (a < NREG);
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) begin
      mreg[r]  = '0;
      mbusy[r] = 1'b0;
    end
  endfunction

  // Writes commit in port order (last writer wins), then an issue re-marks busy.
  function automatic void model_step();
    for (int p = 0; p < NWR; p++) begin
      int a = int'(bus.wr_addr[p*AW +: AW]);
      if (bus.wr_en[p] && valid(a)) begin
        mreg[a]  = bus.wr_data[p*XLEN +: XLEN];
        mbusy[a] = 1'b0;
      end
    end
    if (bus.iss_en && valid(int'(bus.iss_addr))) mbusy[int'(bus.iss_addr)] = 1'b1;
  endfunction

  function automatic void exp_read(input int k, output logic [XLEN-1:0] d, output logic b);
    int a = int'(bus.rd_addr[k*AW +: AW]);
    d = '0;
    b = 1'b0;
    if (!rst && valid(a)) begin
      d = mreg[a];
      b = mbusy[a];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en[p] && int'(bus.wr_addr[p*AW +: AW]) == a) begin
          d = bus.wr_data[p*XLEN +: XLEN];
          b = 1'b0;
        end
      end
      if (bus.iss_en && int'(bus.iss_addr) == a) b = 1'b1;
`endif
    end
  endfunction

  function automatic logic [NREG-1:0] exp_vec();
    logic [NREG-1:0] v = '0;
    for (int r = 0; r < NREG; r++) v[r] = mbusy[r];
    return v;
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += int'(mbusy[r]);
    return c;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NRD; k++) begin
        logic [XLEN-1:0] d;
        logic            b;
        exp_read(k, d, b);
        check($sformatf("rd_data[%0d]", k), 64'(bus.rd_data[k*XLEN +: XLEN]), 64'(d));
        check($sformatf("rd_busy[%0d]", k), 64'(bus.rd_busy[k]), 64'(b));
      end
      check("busy_vec", 64'(bus.busy_vec), 64'(exp_vec()));
      check("busy_cnt", 64'(bus.busy_cnt), 64'(exp_cnt()));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else model_step();
    #1;
  endtask

  task automatic quiet();
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.iss_en  = 1'b0;
    bus.iss_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    bus.wr_en[p]              = 1'b1;
    bus.wr_addr[p*AW +: AW]   = AW'(a);
    bus.wr_data[p*XLEN +: XLEN] = d;
  endtask

  initial begin
    logic [31:0] r0, r1, r2;
    quiet();
    set_rd(0, 0);
    model_clear();
    rst = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int a = 0; a < NREG; a += 2) begin
      set_rd(a, a + 1);
      #1;
      check("reset rd_data0", 64'(bus.rd_data[XLEN-1:0]), 64'(0));
      check("reset rd_data1", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'(0));
      check("reset rd_busy", 64'(bus.rd_busy), 64'(0));
      tick();
    end
    check("reset busy_cnt", 64'(bus.busy_cnt), 64'(0));

    bus.iss_en = 1'b1; bus.iss_addr = AW'(5);
    tick();
    quiet();
    check("issue5 busy_vec[5]", 64'(bus.busy_vec[5]), 64'(1));
    check("issue5 busy_cnt", 64'(bus.busy_cnt), 64'(1));
    set_wr(0, 5, 32'hDEADBEEF);
    tick();
    quiet();
    set_rd(5, 0);
    #1;
    check("write5 rd_data", 64'(bus.rd_data[XLEN-1:0]), 64'(32'hDEADBEEF));
    check("write5 busy_cnt", 64'(bus.busy_cnt), 64'(0));

    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    tick();
    quiet();
    set_rd(7, 0);
    #1;
    check("conflict reg7", 64'(bus.rd_data[XLEN-1:0]), 64'(32'h22));

    set_wr(0, 0, 32'hFFFFFFFF);
    bus.iss_en = 1'b1; bus.iss_addr = '0;
    tick();
    quiet();
    set_rd(0, 0);
    #1;
    check("reg0 rd_data", 64'(bus.rd_data[XLEN-1:0]), 64'(0));
    check("reg0 busy_vec", 64'(bus.busy_vec), 64'(0));
    check("reg0 busy_cnt", 64'(bus.busy_cnt), 64'(0));

    bus.iss_en = 1'b1; bus.iss_addr = AW'(9);
    tick();
    quiet();
    check("issue9 busy_cnt", 64'(bus.busy_cnt), 64'(1));
    set_wr(1, 9, 32'hABCD);
    bus.iss_en = 1'b1; bus.iss_addr = AW'(9);
    tick();
    quiet();
    set_rd(9, 0);
    #1;
    check("wr+iss9 busy_vec[9]", 64'(bus.busy_vec[9]), 64'(1));
    check("wr+iss9 busy_cnt", 64'(bus.busy_cnt), 64'(1));
    check("wr+iss9 data", 64'(bus.rd_data[XLEN-1:0]), 64'(32'hABCD));

    set_rd(3, 0);
    set_wr(0, 3, 32'h1234);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass same cycle", 64'(bus.rd_data[XLEN-1:0]), 64'(32'h1234));
`else
    check("no-bypass same cycle", 64'(bus.rd_data[XLEN-1:0]), 64'(0));
`endif
    tick();
    quiet();
    #1;
    check("reg3 next cycle", 64'(bus.rd_data[XLEN-1:0]), 64'(32'h1234));
    set_wr(1, 3, 32'h5555);
    rst = 1'b1;
    model_clear();
    #1;
    check("mid-rst rd_data", 64'(bus.rd_data[XLEN-1:0]), 64'(0));
    check("mid-rst busy_vec", 64'(bus.busy_vec), 64'(0));
    check("mid-rst busy_cnt", 64'(bus.busy_cnt), 64'(0));
    quiet();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      bus.wr_en   = r0[NWR-1:0];
      bus.wr_addr = r0[8 +: NWR*AW];
      if (r0[20 +: 2] == 2'd0) bus.wr_addr[AW +: AW] = bus.wr_addr[0 +: AW];
      bus.wr_data = {r1, r2};
      bus.iss_en  = r0[22];
      bus.iss_addr = r0[23] ? bus.wr_addr[0 +: AW] : r1[AW-1:0];
      bus.rd_addr = r2[0 +: NRD*AW];
      if (r0[24 +: 2] == 2'd0) bus.rd_addr[0 +: AW] = bus.wr_addr[AW +: AW];
      if (r0[26]) bus.rd_addr[AW +: AW] = bus.iss_addr;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_clear();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
